// File: rtl/chan_buf_reader.sv
// chan_buf_reader: reads one frame of words from a buffer memory and streams
// them out with valid/ready handshaking.
//
// A start pulse in IDLE captures base_addr/length and moves to RUN. Reads are
// issued to the memory (one-cycle read latency). Returned words land in a
// 2-entry output FIFO whose head drives the output stream. A read is issued
// only when fewer than length words have been issued, fewer than words_written
// words have been issued, and the FIFO has room for it. When the final word
// handshakes, the block spends one cycle in DONE (done pulse) and returns to
// IDLE. A start with length 0 goes straight to DONE.
//
// Optional feature (macro CHAN_BUF_READER_REPLAY_EN): adds input replay. A
// replay pulse in IDLE, after at least one completed frame, rereads the last
// captured frame. The replayed frame ignores words_written. start wins if both
// are high.
//
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   start                single-cycle frame request (sampled in IDLE only)
//   base_addr, length    frame placement and size, captured on accepted start
//   words_written        producer fill level; limits how far reads may run
//   mem_rd_en/addr/data  buffer read port, data valid one cycle after rd_en
//   out_valid/data/last  output stream, out_last marks the final word
//   out_ready            downstream accept
//   busy, done           RUN-state flag and completion pulse
//   replay               (CHAN_BUF_READER_REPLAY_EN only) reread last frame
module chan_buf_reader #(
  parameter int DEPTH  = 16384,
  parameter int DATA_W = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [AW-1:0]     base_addr,
  input  logic [AW:0]       length,
  input  logic [AW:0]       words_written,
`ifdef CHAN_BUF_READER_REPLAY_EN
  input  logic              replay,
`endif
  output logic              mem_rd_en,
  output logic [AW-1:0]     mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              r_state;
  logic [AW:0]         r_len;
  logic [AW:0]         r_issued;
  logic [AW-1:0]       r_next_addr;
  logic [AW-1:0]       r_rd_addr;
  logic                r_pend;
  logic                r_pend_last;
  logic [DATA_W-1:0]   r_fifo_data [2];
  logic [1:0]          r_fifo_last;
  logic                r_head;
  logic                r_tail;
  logic [1:0]          r_cnt;
`ifdef CHAN_BUF_READER_REPLAY_EN
  logic [AW-1:0]       r_base;
  logic                r_no_ww;
  logic                r_has_frame;
`endif

  logic                w_accept_start;
  logic                w_accept_replay;
  logic                w_launch;
  logic [AW:0]         w_launch_len;
  logic                w_ignore_ww;
  logic                w_pop;
  logic [1:0]          w_occ;
  logic                w_rd_en;
  logic                w_issue_last;
  logic [AW-1:0]       w_addr_inc;

  assign w_accept_start = (r_state == S_IDLE) && start;
`ifdef CHAN_BUF_READER_REPLAY_EN
  assign w_accept_replay = (r_state == S_IDLE) && replay && r_has_frame && !start;
  assign w_launch_len    = w_accept_start ? length : r_len;
  assign w_ignore_ww     = r_no_ww;
`else
  assign w_accept_replay = 1'b0;
  assign w_launch_len    = length;
  assign w_ignore_ww     = 1'b0;
`endif
  assign w_launch = w_accept_start || w_accept_replay;

  assign out_valid = (r_cnt != 2'd0);
  assign out_data  = out_valid ? r_fifo_data[r_head] : '0;
  assign out_last  = out_valid && r_fifo_last[r_head];
  assign w_pop     = out_valid && out_ready;

  // Words that will still occupy the FIFO after this cycle's pop, counting
  // the word arriving from memory now. A new read may be issued only if its
  // word is guaranteed a slot even if downstream stalls from here on; using
  // the post-pop count is what allows one word per cycle with two entries.
  assign w_occ = r_cnt + {1'b0, r_pend} - {1'b0, w_pop};

  assign w_rd_en = (r_state == S_RUN) && (r_issued < r_len) &&
                   (w_ignore_ww || (r_issued < words_written)) &&
                   (w_occ < 2'd2);

  assign w_issue_last = (r_issued == r_len - CNT_ONE);
  // Compare-based wrap so DEPTH need not be a power of two.
  assign w_addr_inc   = (r_next_addr == LAST_ADDR) ? '0 : r_next_addr + ADDR_ONE;

  assign mem_rd_en   = w_rd_en;
  // Show the last issued address whenever no read is being issued.
  assign mem_rd_addr = w_rd_en ? r_next_addr : r_rd_addr;

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_issued    <= '0;
      r_rd_addr   <= '0;
      r_pend      <= 1'b0;
      r_head      <= 1'b0;
      r_tail      <= 1'b0;
      r_cnt       <= 2'd0;
`ifdef CHAN_BUF_READER_REPLAY_EN
      r_no_ww     <= 1'b0;
      r_has_frame <= 1'b0;
`endif
    end else begin
      r_pend <= w_rd_en;
      if (w_rd_en) begin
        r_issued  <= r_issued + CNT_ONE;
        r_rd_addr <= r_next_addr;
      end
      if (r_pend) r_tail <= ~r_tail;
      if (w_pop)  r_head <= ~r_head;
      r_cnt <= r_cnt + {1'b0, r_pend} - {1'b0, w_pop};

      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_issued <= '0;
            r_state  <= (w_launch_len == '0) ? S_DONE : S_RUN;
`ifdef CHAN_BUF_READER_REPLAY_EN
            r_no_ww  <= w_accept_replay;
`endif
          end
        end
        S_RUN: begin
          if (w_pop && out_last) r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
`ifdef CHAN_BUF_READER_REPLAY_EN
          r_has_frame <= 1'b1;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Frame parameters, read address walk and FIFO storage; visibility of the
  // stored words is governed by the control registers above.
  always_ff @(posedge clk) begin
    if (w_accept_start) begin
      r_len       <= length;
      r_next_addr <= base_addr;
`ifdef CHAN_BUF_READER_REPLAY_EN
      r_base      <= base_addr;
`endif
    end
`ifdef CHAN_BUF_READER_REPLAY_EN
    else if (w_accept_replay) begin
      r_next_addr <= r_base;
    end
`endif
    else if (w_rd_en) begin
      r_next_addr <= w_addr_inc;
      r_pend_last <= w_issue_last;
    end

    if (r_pend) begin
      r_fifo_data[r_tail] <= mem_rd_data;
      r_fifo_last[r_tail] <= r_pend_last;
    end
  end

endmodule

// File: tb/tb_chan_buf_reader.sv
module tb_chan_buf_reader;
  localparam int DEPTH  = 16384;
  localparam int DATA_W = 32;
  localparam int AW     = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [AW-1:0]     base_addr;
  logic [AW:0]       length;
  logic [AW:0]       words_written;
`ifdef CHAN_BUF_READER_REPLAY_EN
  logic              replay;
`endif
  logic              mem_rd_en;
  logic [AW-1:0]     mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;
  logic              busy;
  logic              done;

  chan_buf_reader #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .base_addr     (base_addr),
    .length        (length),
    .words_written (words_written),
`ifdef CHAN_BUF_READER_REPLAY_EN
    .replay        (replay),
`endif
    .mem_rd_en     (mem_rd_en),
    .mem_rd_addr   (mem_rd_addr),
    .mem_rd_data   (mem_rd_data),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_last      (out_last),
    .out_ready     (out_ready),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0]       seed = 32'h1234_5678;
  logic [DATA_W-1:0] exp_data [$];
  logic              exp_last [$];
  logic [AW-1:0]     exp_addr [$];
  int                phase = 0;      // 0 idle, 1 frame running, 2 completion cycle
  int                n_out = 0;      // words read but not yet accepted downstream
  int                frm_iss = 0;    // reads issued in the current frame
  int                frm_acc = 0;    // words accepted in the current frame
  bit                frame_no_ww = 0;
`ifdef CHAN_BUF_READER_REPLAY_EN
  logic [AW-1:0]     last_base;
  int                last_len = 0;
  bit                have_frame = 0;
`endif

  function automatic logic [DATA_W-1:0] mem_word(input int addr);
    return (32'(addr) * 32'h9E37_79B1) ^ seed;
  endfunction

  // Buffer memory: one-cycle read latency, garbage when not read.
  always @(posedge clk)
    mem_rd_data <= mem_rd_en ? mem_word(int'(mem_rd_addr)) : $urandom;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic accept_frame(input int base, input int len, input bit no_ww);
    exp_data.delete(); exp_last.delete(); exp_addr.delete();
    for (int i = 0; i < len; i++) begin
      exp_addr.push_back(AW'((base + i) % DEPTH));
      exp_data.push_back(mem_word((base + i) % DEPTH));
      exp_last.push_back(i == len - 1);
    end
    phase = (len == 0) ? 2 : 1;
    n_out = 0; frm_iss = 0; frm_acc = 0;
    frame_no_ww = no_ww;
  endtask

  // Checks the current cycle (inputs already applied), then advances the model
  // across the coming rising edge.
  task automatic check_cycle();
    bit hs;
    bit hs_last;
    hs = (out_valid === 1'b1) && (out_ready === 1'b1);
    hs_last = 1'b0;
    chk("busy", busy, phase == 1);
    chk("done", done, phase == 2);
    if (phase != 1) begin
      chk("valid_outside_run", out_valid, 1'b0);
      chk("rd_en_outside_run", mem_rd_en, 1'b0);
    end
    if (mem_rd_en === 1'b1) begin
      chk("rd_expected", exp_addr.size() != 0, 1'b1);
      if (exp_addr.size() != 0) chk("mem_rd_addr", mem_rd_addr, exp_addr.pop_front());
      chk("ww_limit", frame_no_ww || (frm_iss < int'(words_written)), 1'b1);
      chk("pending_lt2", (n_out - int'(hs)) < 2, 1'b1);
      frm_iss++;
      n_out++;
    end
    if (hs) begin
      chk("word_expected", exp_data.size() != 0, 1'b1);
      if (exp_data.size() != 0) begin
        hs_last = exp_last[0];
        chk("out_data", out_data, exp_data.pop_front());
        chk("out_last", out_last, exp_last.pop_front());
      end
      n_out--;
      frm_acc++;
    end
    if (reset) begin
      phase = 0; n_out = 0;
      exp_data.delete(); exp_last.delete(); exp_addr.delete();
`ifdef CHAN_BUF_READER_REPLAY_EN
      have_frame = 0;
`endif
    end else begin
      case (phase)
        0: begin
          if (start) begin
            seed = $urandom;
            accept_frame(int'(base_addr), int'(length), 1'b0);
`ifdef CHAN_BUF_READER_REPLAY_EN
            last_base = base_addr;
            last_len  = int'(length);
`endif
          end
`ifdef CHAN_BUF_READER_REPLAY_EN
          else if (replay && have_frame) accept_frame(int'(last_base), last_len, 1'b1);
`endif
        end
        1: if (hs && hs_last) phase = 2;
        default: begin
          phase = 0;
`ifdef CHAN_BUF_READER_REPLAY_EN
          have_frame = 1;
`endif
        end
      endcase
    end
  endtask

  task automatic tick();
    #2;
    check_cycle();
    @(negedge clk);
  endtask

  // mode 0: ready held high; 1: ready toggles; 2: random ready, random
  // words_written walk toward tgt, stray start pulses while busy.
  task automatic run_frame(input int mode, input int tgt, input int max_cyc);
    int k;
    k = 0;
    start = 1'b0;
    while ((phase != 0 || exp_data.size() != 0) && k < max_cyc) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ~out_ready;
        default: begin
          out_ready = ($urandom % 3) != 0;
          if (($urandom % 8) < 5) begin
            if (int'(words_written) < tgt) words_written = words_written + 1'b1;
          end else if (($urandom % 8) == 0 && words_written != '0) begin
            words_written = words_written - 1'b1;
          end
          start     = (phase != 0) && (($urandom % 6) == 0);
          base_addr = AW'($urandom);
          length    = (AW+1)'($urandom_range(0, 30));
        end
      endcase
      tick();
      k++;
    end
    start = 1'b0;
    chk("frame_completes", (phase == 0) && (exp_data.size() == 0), 1'b1);
  endtask

  task automatic launch(input int base, input int len, input int ww);
    base_addr = AW'(base);
    length = (AW+1)'(len);
    words_written = (AW+1)'(ww);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int k;
    int len;
    reset = 1'b1; start = 1'b0; base_addr = '0; length = '0;
    words_written = '0; out_ready = 1'b1;
`ifdef CHAN_BUF_READER_REPLAY_EN
    replay = 1'b0;
`endif
    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_mem_rd_en", mem_rd_en, 1'b0);
    chk("rst_mem_rd_addr", mem_rd_addr, '0);

    // Basic 4-word frame: 2-cycle latency, back-to-back words, done after last.
    launch(0, 4, 4);
    chk("lat_cycle1_valid", out_valid, 1'b0);
    tick();
    chk("lat_cycle2_valid", out_valid, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("stream_valid", out_valid, 1'b1);
      chk("stream_last", out_last, i == 3);
      tick();
    end
    chk("done_after_last", done, 1'b1);
    run_frame(0, 4, 50);

    // Address wrap at the top of the buffer.
    launch(DEPTH - 2, 4, 4);
    run_frame(0, 4, 50);

    // Downstream ready toggling every cycle.
    out_ready = 1'b0;
    launch($urandom_range(0, DEPTH - 1), 8, 8);
    run_frame(1, 8, 100);

    // Producer behind the reader: 3 words available for 10 cycles.
    out_ready = 1'b1;
    launch(100, 6, 3);
    for (int i = 0; i < 10; i++) tick();
    chk("stall_words_delivered", frm_acc, 3);
    chk("stall_valid", out_valid, 1'b0);
    words_written = 7'd6;
    run_frame(0, 6, 50);
    chk("stall_total_words", frm_acc, 6);

    // Zero-length frame.
    launch(5, 0, 0);
    chk("len0_done", done, 1'b1);
    chk("len0_valid", out_valid, 1'b0);
    run_frame(0, 0, 10);

    // Reset in the middle of a frame.
    launch(200, 8, 8);
    k = 0;
    while (frm_acc < 2 && k < 20) begin tick(); k++; end
    chk("midreset_reached_2", frm_acc >= 2, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset_valid", out_valid, 1'b0);
    chk("midreset_busy", busy, 1'b0);
    tick();
    tick();
    launch(300, 2, 2);
    run_frame(0, 2, 50);
    chk("after_reset_words", frm_acc, 2);

    // Randomized frames.
    for (int f = 0; f < 8; f++) begin
      len = $urandom_range(1, 24);
      out_ready = 1'b1;
      launch(($urandom % 2) ? (DEPTH - 1 - $urandom_range(0, 6)) : $urandom_range(0, DEPTH - 1),
             len, $urandom_range(0, len));
      run_frame(2, len, 2000);
      chk("rand_frame_words", frm_acc, len);
    end

`ifdef CHAN_BUF_READER_REPLAY_EN
    out_ready = 1'b1;
    launch(40, 3, 3);
    run_frame(0, 3, 50);
    words_written = '0;
    replay = 1'b1;
    tick();
    replay = 1'b0;
    chk("replay_busy", busy, 1'b1);
    run_frame(0, 0, 50);
    chk("replay_words", frm_acc, 3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
